// File: rtl/segment_packer.sv
// Packs 16-bit pipe-in words into 128-bit segment records and writes them to the segment FIFO.
// Optional record validation (on_counts / repeat_counts sanity) is enabled with SEGMENT_VALIDATE_EN.
module segment_packer #(
  parameter int WORDS_PER_REC = 8,
  parameter int CNT_W         = 16
) (
  input  logic             ti_clk,
  input  logic             reset_n,
  input  logic             pipe_write,
  input  logic [15:0]      pipe_data,
  input  logic             flush,
  input  logic             err_clear,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [127:0]     fifo_din,
  output logic [CNT_W-1:0] rec_count,
  output logic             partial,
`ifdef SEGMENT_VALIDATE_EN
  output logic             bad_rec_err,
`endif
  output logic             overflow_err
);

  localparam int IDX_W = $clog2(WORDS_PER_REC);
  localparam int SH_W  = 16 * (WORDS_PER_REC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_REC - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_PEND  = 1'b1;

  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [0:0]       state_q, state_d;
  logic [127:0]     pend_q, pend_d;
  logic             wr_en_q, wr_en_d;
  logic [127:0]     din_q, din_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             partial_q, partial_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;

  logic         rec_done_s;
  logic         rec_ok_s;
  logic         inc_s;
  logic         ovf_set_s;
  logic [127:0] record_s;

  assign record_s   = {shreg_q, pipe_data};
  assign rec_done_s = pipe_write & (word_idx_q == LAST_IDX) & ~flush;

  // The all-zero record is the legal retrigger-wait marker, so it is exempt from validation.
`ifdef SEGMENT_VALIDATE_EN
  assign rec_ok_s = (record_s == 128'd0) ||
                    ((record_s[127:80] != 48'd0) && (record_s[31:0] != 32'd0));
`else
  assign rec_ok_s = 1'b1;
`endif

  always_comb begin
    word_idx_d = word_idx_q;
    shreg_d    = shreg_q;
    state_d    = state_q;
    pend_d     = pend_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    inc_s      = 1'b0;
    ovf_set_s  = 1'b0;

    if (flush) begin
      word_idx_d = '0;
      state_d    = S_EMPTY;
    end else begin
      if (pipe_write) begin
        shreg_d    = {shreg_q[SH_W-17:0], pipe_data};
        word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_W'(1);
      end else begin
        word_idx_d = word_idx_q;
      end

      // A pending record leaving on the same edge frees the slot for a newly completed one.
      case (state_q)
        S_EMPTY: begin
          if (rec_done_s && rec_ok_s) begin
            if (!fifo_full) begin
              wr_en_d = 1'b1;
              din_d   = record_s;
              inc_s   = 1'b1;
            end else begin
              pend_d  = record_s;
              state_d = S_PEND;
            end
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_PEND: begin
          if (!fifo_full) begin
            wr_en_d = 1'b1;
            din_d   = pend_q;
            inc_s   = 1'b1;
            if (rec_done_s && rec_ok_s) begin
              pend_d = record_s;
            end else begin
              state_d = S_EMPTY;
            end
          end else if (rec_done_s && rec_ok_s) begin
            ovf_set_s = 1'b1;
          end else begin
            state_d = S_PEND;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    cnt_d     = err_clear ? {{(CNT_W-1){1'b0}}, inc_s}
                          : cnt_q + {{(CNT_W-1){1'b0}}, inc_s};
    ovf_d     = (ovf_q & ~err_clear) | ovf_set_s;
    bad_d     = (bad_q & ~err_clear) | (rec_done_s & ~rec_ok_s);
    partial_d = (word_idx_d != '0);
  end

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx_q <= '0;
      shreg_q    <= '0;
      state_q    <= S_EMPTY;
      pend_q     <= '0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      cnt_q      <= '0;
      partial_q  <= 1'b0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      word_idx_q <= word_idx_d;
      shreg_q    <= shreg_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      partial_q  <= partial_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign rec_count    = cnt_q;
  assign partial      = partial_q;
  assign overflow_err = ovf_q;
`ifdef SEGMENT_VALIDATE_EN
  assign bad_rec_err  = bad_q;
`else
  logic unused_bad_s;
  assign unused_bad_s = bad_q;
`endif

endmodule
